// File: rtl/atomic_sequencer.sv
// RV32A sequencer: runs LR.W / SC.W / AMO*.W read-modify-write on the data port and owns the LR/SC reservation.
// Optional reservation expiry counter is compiled in with `define AMO_RESV_TIMEOUT_EN.
module atomic_sequencer #(
  parameter int XLEN         = 32,
  parameter int RESV_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_lr,
  input  logic            is_sc,
  input  logic            is_amo,
  input  logic [4:0]      amo_funct5,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  input  logic            snoop_valid,
  input  logic [XLEN-1:0] snoop_addr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            misaligned
);

  if (RESV_TIMEOUT < 1 || RESV_TIMEOUT > 127) begin : g_bad_timeout
    $error("RESV_TIMEOUT must fit the 7-bit reservation counter");
  end

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [XLEN-3:0]   addr_q;
  logic [XLEN-1:0]   rs2_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        funct5_q;
  logic              op_lr, op_sc, mis_q;
  logic              flush_pend, resv_pend;
  logic              resv_valid, resv_live;
  logic [XLEN-3:0]   resv_addr;
  logic              accept, misalign_in, new_sc, sc_hit;
  logic              snoop_hit_resv, snoop_hit_op, resv_set;

  function automatic logic [XLEN-1:0] amo_f(input logic [4:0] f, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    case (f)
      5'b00000: amo_f = a + b;
      5'b00100: amo_f = a ^ b;
      5'b01100: amo_f = a & b;
      5'b01000: amo_f = a | b;
      5'b10000: amo_f = ($signed(a) < $signed(b)) ? a : b;
      5'b10100: amo_f = ($signed(a) < $signed(b)) ? b : a;
      5'b11000: amo_f = (a < b) ? a : b;
      5'b11100: amo_f = (a < b) ? b : a;
      default:  amo_f = b;
    endcase
  endfunction

  assign accept         = start && !flush;
  assign misalign_in    = addr[1:0] != 2'b00;
  assign new_sc         = is_sc && !is_lr && !is_amo;
  assign snoop_hit_resv = snoop_valid && (snoop_addr[XLEN-1:2] == resv_addr);
  assign snoop_hit_op   = snoop_valid && (snoop_addr[XLEN-1:2] == addr_q);
  assign sc_hit         = resv_live && (resv_addr == addr[XLEN-1:2]) && !snoop_hit_resv;
  // The LR reservation is committed only as done is delivered, so a flush in DONE leaves it untouched.
  assign resv_set       = (state == DONE) && !flush && resv_pend && !snoop_hit_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misalign_in)           state_nxt = DONE;
          else if (is_lr || is_amo)  state_nxt = READ;
          else if (is_sc)            state_nxt = sc_hit ? WRITE : DONE;
        end
      end
      READ: begin
        if (flush)          state_nxt = IDLE;
        else if (mem_ready) state_nxt = op_lr ? DONE : WRITE;
      end
      WRITE: begin
        // A write, once issued, always completes; a flush seen meanwhile only suppresses done.
        if (mem_ready) state_nxt = (flush || flush_pend) ? IDLE : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake: in READ/WRITE mem_req is high and mem_addr/mem_we/mem_wdata hold still until a
  // cycle with mem_ready=1, which completes the transfer; mem_req depends on state only.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state)
      READ: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = {addr_q, 2'b00};
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        busy      = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = wdata_q;
      end
      DONE: begin
        done       = !flush;
        misaligned = !flush && mis_q;
      end
      default: ;
    endcase
  end

  assign result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rs2_q      <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      funct5_q   <= '0;
      op_lr      <= 1'b0;
      op_sc      <= 1'b0;
      mis_q      <= 1'b0;
      flush_pend <= 1'b0;
      resv_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q     <= addr[XLEN-1:2];
          rs2_q      <= rs2_data;
          wdata_q    <= rs2_data;
          funct5_q   <= amo_funct5;
          op_lr      <= is_lr;
          op_sc      <= new_sc;
          mis_q      <= misalign_in;
          flush_pend <= 1'b0;
          resv_pend  <= 1'b0;
          if (misalign_in)  result_q <= '0;
          else if (new_sc)  result_q <= sc_hit ? '0 : XLEN'(1);
        end
        READ: if (!flush && mem_ready) begin
          result_q <= mem_rdata;
          if (op_lr) resv_pend <= !snoop_hit_op;
          else       wdata_q   <= amo_f(funct5_q, mem_rdata, rs2_q);
        end
        WRITE: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_ready && op_sc) result_q <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef AMO_RESV_TIMEOUT_EN
  logic [6:0] resv_cnt;

  assign resv_live = resv_valid && (resv_cnt != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  resv_cnt <= '0;
    else if (resv_set)           resv_cnt <= 7'(RESV_TIMEOUT);
    else if (resv_cnt != 7'd0)   resv_cnt <= resv_cnt - 7'd1;
  end
`else
  assign resv_live = resv_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (resv_set) begin
      resv_valid <= 1'b1;
      resv_addr  <= addr_q;
    end else if ((state == IDLE) && accept && new_sc) begin
      resv_valid <= 1'b0;
    end else if (snoop_hit_resv) begin
      resv_valid <= 1'b0;
`ifdef AMO_RESV_TIMEOUT_EN
    end else if (!resv_live) begin
      resv_valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_atomic_sequencer.sv
// Testbench for atomic_sequencer: AMO vector table, hand-written LR/SC/flush/snoop sequences,
// then randomized operations against a reservation/memory reference model.
module tb_atomic_sequencer;

`ifdef AMO_RESV_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 0;
`endif

  logic        clk, rst_n, start, is_lr, is_sc, is_amo, flush, snoop_valid;
  logic [4:0]  amo_funct5;
  logic [31:0] addr, rs2_data, snoop_addr, mem_addr, mem_wdata, mem_rdata, result;
  logic        mem_req, mem_we, mem_ready, busy, done, misaligned;

  atomic_sequencer #(.XLEN(32), .RESV_TIMEOUT(TB_TO == 0 ? 64 : TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_lr(is_lr), .is_sc(is_sc), .is_amo(is_amo),
    .amo_funct5(amo_funct5), .addr(addr), .rs2_data(rs2_data), .flush(flush),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .result(result), .misaligned(misaligned)
  );

  // clock / reset
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int vectors = 0, miscompares = 0;
  logic [31:0] dmem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // results of the last run_op
  int          r_done, r_nrd, r_nwr, r_start_cyc;
  logic [31:0] r_res, r_rd_addr, r_wr_addr, r_wr_data;
  logic        r_mis;
  logic [15:0] r_busy;

  // driver: issues one op (kind 0=LR 1=SC 2=AMO) and acts as the memory with `waits` stall cycles per phase
  task automatic run_op(input int kind, input logic [4:0] f5, input logic [31:0] a,
                        input logic [31:0] rs2, input int waits, input int flush_k,
                        input int snoop_k, input logic [31:0] snoop_a);
    int wcnt; bit fin, held, h_we;
    logic [31:0] h_addr, h_wdata;
    r_done = -1; r_nrd = 0; r_nwr = 0; r_busy = '0; r_res = '0; r_mis = 1'b0;
    wcnt = 0; fin = 0; held = 0; h_we = 0; h_addr = '0; h_wdata = '0; r_start_cyc = cyc;
    for (int k = 0; k < 40 && !fin; k++) begin
      start = (k == 0);
      if (k == 0) begin
        is_lr = (kind == 0); is_sc = (kind == 1); is_amo = (kind == 2);
        amo_funct5 = f5; addr = a; rs2_data = rs2;
      end else begin
        is_lr = 1'($urandom_range(0, 1)); is_sc = 1'($urandom_range(0, 1));
        is_amo = 1'($urandom_range(0, 1)); amo_funct5 = 5'($urandom);
        addr = $urandom; rs2_data = $urandom;
      end
      flush = (k == flush_k);
      snoop_valid = (k == snoop_k);
      snoop_addr = snoop_a;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (held) begin
          chk("hold_addr", mem_addr, h_addr);
          chk("hold_we", 32'(mem_we), 32'(h_we));
          chk("hold_wdata", mem_wdata, h_wdata);
        end
        held = 1; h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        wcnt++;
        if (wcnt > waits) begin
          mem_ready = 1'b1; wcnt = 0; held = 0;
          if (mem_we) begin
            dmem[mem_addr[9:2]] = mem_wdata;
            r_nwr++; r_wr_addr = mem_addr; r_wr_data = mem_wdata;
          end else begin
            mem_rdata = dmem[mem_addr[9:2]];
            r_nrd++; r_rd_addr = mem_addr;
          end
        end
      end else begin
        held = 0;
      end
      @(negedge clk);
      if (k < 16) r_busy[k] = busy;
      if (done) begin
        r_done = k; r_res = result; r_mis = misaligned; fin = 1;
      end else if (k > 0 && !busy) begin
        fin = 1;
      end
      @(posedge clk); #1;
    end
    if (!fin) begin
      vectors++; miscompares++;
      $display("FAIL op_timeout: got no return to idle expected within 40 cycles");
    end
    start = 0; flush = 0; snoop_valid = 0; mem_ready = 0;
  endtask

  task automatic idle(input int n, input bit sv, input logic [31:0] sa);
    for (int i = 0; i < n; i++) begin
      snoop_valid = sv && (i == 0);
      snoop_addr = sa;
      @(posedge clk); #1;
    end
    snoop_valid = 0;
  endtask

  // reference model: reservation as (valid, word, first live cycle), memory as an array
  bit          ref_rv;
  logic [29:0] ref_ra;
  int          ref_c0;
  logic [31:0] rmem [256];

  function automatic logic [31:0] amo_ref(input logic [4:0] f, input logic [31:0] m, input logic [31:0] r);
    longint sm, sr, um, ur;
    sm = longint'($signed(m)); sr = longint'($signed(r));
    um = longint'({32'b0, m}); ur = longint'({32'b0, r});
    case (f)
      5'b00000: return 32'((um + ur) % 64'h1_0000_0000);
      5'b00100: return m ^ r;
      5'b01100: return m & r;
      5'b01000: return m | r;
      5'b10000: return (sm <= sr) ? m : r;
      5'b10100: return (sm >= sr) ? m : r;
      5'b11000: return (um <= ur) ? m : r;
      5'b11100: return (um >= ur) ? m : r;
      default:  return r;
    endcase
  endfunction

  task automatic model_op(input int kind, input logic [4:0] f5, input logic [31:0] a,
                          input logic [31:0] rs2, input int waits);
    int s, lat, nrd, nwr;
    logic [31:0] exp_res, exp_wd;
    bit live, mis;
    s = cyc; nrd = 0; nwr = 0; exp_wd = '0; exp_res = '0;
    mis = (a[1:0] != 2'b00);
    live = ref_rv && (TB_TO == 0 || (s - ref_c0) < TB_TO);
    if (mis) begin
      lat = 1;
      if (kind == 1) ref_rv = 0;
    end else if (kind == 0) begin
      nrd = 1; lat = 2 + waits; exp_res = rmem[a[9:2]];
      ref_rv = 1; ref_ra = a[31:2]; ref_c0 = s + lat + 1;
    end else if (kind == 1) begin
      if (live && ref_ra == a[31:2]) begin
        nwr = 1; lat = 2 + waits; exp_wd = rs2; rmem[a[9:2]] = rs2;
      end else begin
        lat = 1; exp_res = 32'd1;
      end
      ref_rv = 0;
    end else begin
      nrd = 1; nwr = 1; lat = 3 + 2 * waits;
      exp_res = rmem[a[9:2]];
      exp_wd = amo_ref(f5, exp_res, rs2);
      rmem[a[9:2]] = exp_wd;
    end
    run_op(kind, f5, a, rs2, waits, -1, -1, 32'h0);
    chk("rnd_latency", 32'(r_done), 32'(lat));
    chk("rnd_result", r_res, exp_res);
    chk("rnd_misaligned", 32'(r_mis), 32'(mis));
    chk("rnd_reads", 32'(r_nrd), 32'(nrd));
    chk("rnd_writes", 32'(r_nwr), 32'(nwr));
    if (nrd > 0) chk("rnd_rd_addr", r_rd_addr, {a[31:2], 2'b00});
    if (nwr > 0) begin
      chk("rnd_wr_addr", r_wr_addr, {a[31:2], 2'b00});
      chk("rnd_wr_data", r_wr_data, exp_wd);
    end
  endtask

  typedef struct {
    logic [4:0]  f5;
    logic [31:0] mem_init;
    logic [31:0] rs2;
    logic [31:0] exp_w;
  } amo_vec_t;

  amo_vec_t tbl [11];
  logic [31:0] pool [3];

  initial begin
    tbl[0]  = '{5'b00000, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    tbl[1]  = '{5'b10000, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF};
    tbl[2]  = '{5'b11100, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF};
    tbl[3]  = '{5'b00001, 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D};
    tbl[4]  = '{5'b00100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00};
    tbl[5]  = '{5'b01100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
    tbl[6]  = '{5'b01000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
    tbl[7]  = '{5'b10100, 32'h80000000, 32'h00000001, 32'h00000001};
    tbl[8]  = '{5'b11000, 32'h80000000, 32'h00000001, 32'h00000001};
    tbl[9]  = '{5'b00010, 32'h11111111, 32'h22222222, 32'h22222222};
    tbl[10] = '{5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108;
    for (int i = 0; i < 256; i++) dmem[i] = $urandom;

    rst_n = 0; start = 0; is_lr = 0; is_sc = 0; is_amo = 0; amo_funct5 = '0; addr = '0;
    rs2_data = '0; flush = 0; snoop_valid = 0; snoop_addr = '0; mem_rdata = '0; mem_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_misaligned", 32'(misaligned), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1;
    @(posedge clk); #1;

    // LR then SC to the same word
    dmem[8'h40] = 32'hDEADBEEF;
    run_op(0, 5'h0, 32'h100, 32'h0, 0, -1, -1, 32'h0);
    chk("lr_result", r_res, 32'hDEADBEEF);
    chk("lr_latency", 32'(r_done), 32'd2);
    chk("lr_busy_trace", 32'(r_busy[2:0]), 32'b010);
    run_op(1, 5'h0, 32'h100, 32'h5, 0, -1, -1, 32'h0);
    chk("sc_ok_result", r_res, 32'h0);
    chk("sc_ok_latency", 32'(r_done), 32'd2);
    chk("sc_ok_wr_addr", r_wr_addr, 32'h100);
    chk("sc_ok_wr_data", r_wr_data, 32'h5);

    // snoop to the same word in between
    run_op(0, 5'h0, 32'h100, 32'h0, 0, -1, -1, 32'h0);
    idle(1, 1, 32'h102);
    run_op(1, 5'h0, 32'h100, 32'h9, 0, -1, -1, 32'h0);
    chk("sc_snoop_result", r_res, 32'h1);
    chk("sc_snoop_latency", 32'(r_done), 32'd1);
    chk("sc_snoop_writes", 32'(r_nwr), 32'd0);
    // snoop on the LR read handshake cycle
    run_op(0, 5'h0, 32'h100, 32'h0, 0, -1, 1, 32'h100);
    run_op(1, 5'h0, 32'h100, 32'h9, 0, -1, -1, 32'h0);
    chk("sc_snoop_lr_hs", r_res, 32'h1);
    // snoop on the SC evaluation cycle
    run_op(0, 5'h0, 32'h104, 32'h0, 0, -1, -1, 32'h0);
    run_op(1, 5'h0, 32'h104, 32'h9, 0, -1, 0, 32'h104);
    chk("sc_snoop_same", r_res, 32'h1);
    // snoop to another word leaves the reservation
    run_op(0, 5'h0, 32'h108, 32'h0, 0, -1, -1, 32'h0);
    idle(1, 1, 32'h10C);
    run_op(1, 5'h0, 32'h108, 32'h77, 0, -1, -1, 32'h0);
    chk("sc_snoop_other", r_res, 32'h0);
    chk("sc_snoop_other_wr", r_wr_data, 32'h77);

    // AMO function table, zero-wait memory
    for (int i = 0; i < 11; i++) begin
      dmem[8'h80] = tbl[i].mem_init;
      run_op(2, tbl[i].f5, 32'h200, tbl[i].rs2, 0, -1, -1, 32'h0);
      chk($sformatf("amo%0d_latency", i), 32'(r_done), 32'd3);
      chk($sformatf("amo%0d_result", i), r_res, tbl[i].mem_init);
      chk($sformatf("amo%0d_wdata", i), r_wr_data, tbl[i].exp_w);
      chk($sformatf("amo%0d_mem", i), dmem[8'h80], tbl[i].exp_w);
    end

    // AMOSWAP with three stall cycles per phase
    dmem[8'h41] = 32'hA5A5A5A5;
    run_op(2, 5'b00001, 32'h104, 32'h3C3C3C3C, 3, -1, -1, 32'h0);
    chk("swap_wait_latency", 32'(r_done), 32'd9);
    chk("swap_wait_result", r_res, 32'hA5A5A5A5);
    chk("swap_wait_wdata", r_wr_data, 32'h3C3C3C3C);

    // flush cases
    run_op(0, 5'h0, 32'h100, 32'h0, 2, 2, -1, 32'h0);
    chk("flush_read_done", 32'(r_done), 32'hFFFFFFFF);
    run_op(1, 5'h0, 32'h100, 32'h1, 0, -1, -1, 32'h0);
    chk("flush_read_resv", r_res, 32'h1);
    run_op(0, 5'h0, 32'h108, 32'h0, 0, -1, -1, 32'h0);
    run_op(0, 5'h0, 32'h100, 32'h0, 0, 1, -1, 32'h0);
    chk("flush_read_hs_done", 32'(r_done), 32'hFFFFFFFF);
    run_op(1, 5'h0, 32'h108, 32'h55, 0, -1, -1, 32'h0);
    chk("flush_keeps_resv", r_res, 32'h0);
    run_op(0, 5'h0, 32'h100, 32'h0, 0, 0, -1, 32'h0);
    chk("flush_idle_done", 32'(r_done), 32'hFFFFFFFF);
    chk("flush_idle_reads", 32'(r_nrd), 32'd0);
    run_op(0, 5'h0, 32'h104, 32'h0, 0, 2, -1, 32'h0);
    chk("flush_done_done", 32'(r_done), 32'hFFFFFFFF);
    run_op(1, 5'h0, 32'h104, 32'h1, 0, -1, -1, 32'h0);
    chk("flush_done_resv", r_res, 32'h1);
    dmem[8'h43] = 32'd10;
    run_op(2, 5'b00000, 32'h10C, 32'd5, 2, 5, -1, 32'h0);
    chk("flush_write_done", 32'(r_done), 32'hFFFFFFFF);
    chk("flush_write_writes", 32'(r_nwr), 32'd1);
    chk("flush_write_mem", dmem[8'h43], 32'd15);

    // misaligned SC: no access, clears the reservation
    run_op(0, 5'h0, 32'h100, 32'h0, 0, -1, -1, 32'h0);
    run_op(1, 5'h0, 32'h103, 32'h1, 0, -1, -1, 32'h0);
    chk("mis_latency", 32'(r_done), 32'd1);
    chk("mis_flag", 32'(r_mis), 32'h1);
    chk("mis_result", r_res, 32'h0);
    chk("mis_accesses", 32'(r_nrd + r_nwr), 32'd0);
    run_op(1, 5'h0, 32'h100, 32'h1, 0, -1, -1, 32'h0);
    chk("mis_clears_resv", r_res, 32'h1);

`ifdef AMO_RESV_TIMEOUT_EN
    run_op(0, 5'h0, 32'h100, 32'h0, 0, -1, -1, 32'h0);
    idle(5, 0, 32'h0);
    run_op(1, 5'h0, 32'h100, 32'h1, 0, -1, -1, 32'h0);
    chk("timeout_sc_fail", r_res, 32'h1);
    run_op(0, 5'h0, 32'h100, 32'h0, 0, -1, -1, 32'h0);
    idle(2, 0, 32'h0);
    run_op(1, 5'h0, 32'h100, 32'h1, 0, -1, -1, 32'h0);
    chk("timeout_sc_live", r_res, 32'h0);
`endif

    // randomized ops against the reference model
    for (int i = 0; i < 256; i++) rmem[i] = dmem[i];
    ref_rv = 0; ref_ra = '0; ref_c0 = 0;
    for (int n = 0; n < 200; n++) begin
      int kind, sel, waits;
      logic [31:0] a;
      logic [4:0] f5;
      sel = $urandom_range(0, 19);
      kind = (sel < 8) ? 0 : (sel < 15) ? 1 : 2;
      a = pool[$urandom_range(0, 2)];
      if ($urandom_range(0, 11) == 0) a = a + 32'($urandom_range(1, 3));
      f5 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'({$urandom_range(0, 7), 2'b00});
      waits = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        logic [31:0] sa;
        sa = pool[$urandom_range(0, 2)] + 32'($urandom_range(0, 3));
        idle(1, 1, sa);
        if (ref_rv && sa[31:2] == ref_ra) ref_rv = 0;
      end
      model_op(kind, f5, a, $urandom, waits);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
